// File: rtl/core_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// core_sequencer_pkg
// Shared constants for the multi-cycle core sequencer and its decoder:
//   - seq_state_t : FSM state encodings (also exported on the debug state port)
//   - OPC_LOAD / OPC_STORE : opcodes that take the data-memory path
//   - WAIT_W      : width of the ready wait counter
//   - is_mem_op() : true for opcodes that need a MEM phase
// -----------------------------------------------------------------------------
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6,
        ST_FAULT     = 3'd7
    } seq_state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam int unsigned WAIT_W = 8;

    // Any opcode other than load/store (including unknown ones) skips MEM.
    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OPC_LOAD) || (op == OPC_STORE);
    endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// -----------------------------------------------------------------------------
// core_sequencer_if
// Bundles the sequencer's control, memory handshake, decoder and status
// signals.
//   master modport : the sequencer (drives requests, strobes and status)
//   slave  modport : the surrounding core/memories (drive start, readies and
//                    decoder flags)
// -----------------------------------------------------------------------------
interface core_sequencer_if;

    logic        start;
    logic        imemReady;
    logic [6:0]  opcode;
    logic        regWriteReq;
    logic        memWeReq;
    logic        haltReq;
    logic        dmemReady;

    logic        imemReq;
    logic        irLoad;
    logic        dmemReq;
    logic        dmemWe;
    logic        regWriteStrobe;
    logic        pcUpdate;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [31:0] instret;
    logic [2:0]  state;

    modport master (
        input  start, imemReady, opcode, regWriteReq, memWeReq, haltReq, dmemReady,
        output imemReq, irLoad, dmemReq, dmemWe, regWriteStrobe, pcUpdate,
               busy, halted, fault, instret, state
    );

    modport slave (
        output start, imemReady, opcode, regWriteReq, memWeReq, haltReq, dmemReady,
        input  imemReq, irLoad, dmemReq, dmemWe, regWriteStrobe, pcUpdate,
               busy, halted, fault, instret, state
    );

endinterface

// File: rtl/core_sequencer_seq_wait_timer.sv
// -----------------------------------------------------------------------------
// seq_wait_timer
// Counts cycles spent waiting for a memory ready and flags the cycle in which
// the wait budget is used up.
//   clk, rst_n : clock, async active-low reset
//   clear      : hold the count at zero (asserted outside the waiting states)
//   enable     : this cycle is a wait cycle (request up, ready low)
//   limit      : number of wait cycles allowed (1..255)
//   expired    : this wait cycle is the limit-th one
// -----------------------------------------------------------------------------
module seq_wait_timer
    import core_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [WAIT_W-1:0] limit,
    output logic              expired
);

    logic [WAIT_W-1:0] count_r;

    // Wait-cycle counter: cleared outside wait states, advances per wait cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // The current cycle would be wait number count_r+1; widened so 255 cannot wrap.
    assign expired = (({1'b0, count_r} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
// Multi-cycle control FSM: IDLE -> FETCH -> DECODE -> EXECUTE -> [MEM] ->
// WRITEBACK -> FETCH, with sticky HALT and FAULT states.
//   clk, rst_n : clock, async active-low reset
//   bus        : core_sequencer_if.master (start, readies, decoder flags in;
//                requests, strobes, status, instret and debug state out)
// All outputs except irLoad are registered and change only with the state;
// irLoad is the FETCH state qualified by imemReady so the IR captures the
// word in the same cycle the memory presents it.
// -----------------------------------------------------------------------------
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    core_sequencer_if.master     bus
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = TIMEOUT_CYCLES[WAIT_W-1:0];

    seq_state_t  state_r;
    seq_state_t  next_s;
    logic        imem_req_r;
    logic        dmem_req_r;
    logic        dmem_we_r;
    logic        reg_write_strobe_r;
    logic        pc_update_r;
    logic        busy_r;
    logic        halted_r;
    logic        fault_r;
    logic [31:0] instret_r;

    logic        wait_clear_s;
    logic        wait_enable_s;
    logic        wait_expired_s;

    seq_wait_timer u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wait_clear_s),
        .enable  (wait_enable_s),
        .limit   (WAIT_LIMIT),
        .expired (wait_expired_s)
    );

    // Wait counter control: counts only while a request is outstanding.
    always_comb begin
        wait_clear_s  = 1'b1;
        wait_enable_s = 1'b0;
        if (state_r == ST_FETCH) begin
            wait_clear_s  = 1'b0;
            wait_enable_s = !bus.imemReady;
        end else if (state_r == ST_MEM) begin
            wait_clear_s  = 1'b0;
            wait_enable_s = !bus.dmemReady;
        end else begin
            wait_clear_s  = 1'b1;
            wait_enable_s = 1'b0;
        end
    end

    // Next-state logic; ready is tested before the timeout so it wins a tie.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) next_s = ST_FETCH;
                else           next_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (bus.imemReady)   next_s = ST_DECODE;
                else if (wait_expired_s) next_s = ST_FAULT;
                else                 next_s = ST_FETCH;
            end
            ST_DECODE: begin
                next_s = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (bus.haltReq)                next_s = ST_HALT;
                else if (is_mem_op(bus.opcode)) next_s = ST_MEM;
                else                            next_s = ST_WRITEBACK;
            end
            ST_MEM: begin
                if (bus.dmemReady)   next_s = ST_WRITEBACK;
                else if (wait_expired_s) next_s = ST_FAULT;
                else                 next_s = ST_MEM;
            end
            ST_WRITEBACK: begin
                next_s = ST_FETCH;
            end
            ST_HALT: begin
                next_s = ST_HALT;
            end
            ST_FAULT: begin
                next_s = ST_FAULT;
            end
            default: begin
                next_s = ST_FAULT;
            end
        endcase
    end

    // State register with outputs registered from the next state, plus instret.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= ST_IDLE;
            imem_req_r         <= 1'b0;
            dmem_req_r         <= 1'b0;
            dmem_we_r          <= 1'b0;
            reg_write_strobe_r <= 1'b0;
            pc_update_r        <= 1'b0;
            busy_r             <= 1'b0;
            halted_r           <= 1'b0;
            fault_r            <= 1'b0;
            instret_r          <= 32'd0;
        end else begin
            state_r            <= next_s;
            imem_req_r         <= (next_s == ST_FETCH);
            dmem_req_r         <= (next_s == ST_MEM);
            dmem_we_r          <= (next_s == ST_MEM) && bus.memWeReq;
            reg_write_strobe_r <= (next_s == ST_WRITEBACK) && bus.regWriteReq;
            pc_update_r        <= (next_s == ST_WRITEBACK);
            busy_r             <= (next_s != ST_IDLE) && (next_s != ST_HALT) &&
                                  (next_s != ST_FAULT);
            halted_r           <= (next_s == ST_HALT);
            fault_r            <= (next_s == ST_FAULT);
            // Retire at the end of WRITEBACK; 32-bit add wraps naturally.
            if (state_r == ST_WRITEBACK) begin
                instret_r <= instret_r + 32'd1;
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    assign bus.imemReq        = imem_req_r;
    assign bus.irLoad         = (state_r == ST_FETCH) && bus.imemReady;
    assign bus.dmemReq        = dmem_req_r;
    assign bus.dmemWe         = dmem_we_r;
    assign bus.regWriteStrobe = reg_write_strobe_r;
    assign bus.pcUpdate       = pc_update_r;
    assign bus.busy           = busy_r;
    assign bus.halted         = halted_r;
    assign bus.fault          = fault_r;
    assign bus.instret        = instret_r;
    assign bus.state          = state_r;

endmodule
